// File: rtl/fft_pkg.sv
// Shared types and constants for the folded 32-point radix-2 FFT sequencer.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    localparam int FFT_N     = 32;
    localparam int FFT_LOG2N = 5;
    localparam int TW_IDX_W  = 4;
    localparam int NUM_LANES = 16;

endpackage

// File: rtl/fft_tw_addr_gen.sv
// Combinational twiddle-exponent generator: stage index -> per-lane W32^k exponents.
module fft_tw_addr_gen
    import fft_pkg::*;
(
    input  logic [2:0]                        stage,
    output logic [NUM_LANES*TW_IDX_W-1:0]     tw_idx
);

    logic [TW_IDX_W-1:0] mask;
    logic [2:0]          sh;

    // k = (j mod 2^s) << (4-s); stages 4 and above take the lane number directly.
    always_comb begin
        tw_idx = '0;
        if (stage >= 3'd4) begin
            mask = 4'hF;
            sh   = 3'd0;
        end else begin
            mask = 4'((5'd1 << stage) - 5'd1);
            sh   = 3'd4 - stage;
        end
        for (int j = 0; j < NUM_LANES; j++) begin
            tw_idx[j*TW_IDX_W +: TW_IDX_W] = (4'(j) & mask) << sh;
        end
    end

endmodule

// File: rtl/fft32_stage_ctrl.sv
// Stage sequencer for a time-multiplexed 32-point radix-2 DIT FFT.
// Optional IFFT support (inv_req / tw_conj) is built when FFT_CTRL_INVERSE_EN is defined.
module fft32_stage_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned BFLY_LAT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          buf_load,
    input  logic                          abort,
    output logic                          bf_start,
    output logic                          buf_we,
    output logic [2:0]                    stage,
    output logic [NUM_LANES*TW_IDX_W-1:0] tw_idx,
    output logic                          busy,
    output logic                          out_valid,
    input  logic                          out_ready,
`ifdef FFT_CTRL_INVERSE_EN
    input  logic                          inv_req,
    output logic                          tw_conj,
`endif
    output ctrl_state_t                   state_dbg
);

    localparam logic [3:0] LAT_CNT    = 4'(BFLY_LAT);
    localparam logic [2:0] LAST_STAGE = 3'(FFT_LOG2N - 1);

    ctrl_state_t state, next_state;
    logic [3:0]  cnt, next_cnt;
    logic [2:0]  next_stage;
    logic        bf_start_d, buf_we_d;
    logic [NUM_LANES*TW_IDX_W-1:0] tw_next, tw_idx_d;

    fft_tw_addr_gen u_tw_gen (
        .stage  (next_stage),
        .tw_idx (tw_next)
    );

    // Registered outputs are loaded from next-state values so they line up
    // with the cycle in which the state they describe is current.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            stage    <= '0;
            tw_idx   <= '0;
            bf_start <= 1'b0;
            buf_we   <= 1'b0;
        end else begin
            state    <= next_state;
            cnt      <= next_cnt;
            stage    <= next_stage;
            tw_idx   <= tw_idx_d;
            bf_start <= bf_start_d;
            buf_we   <= buf_we_d;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_stage = stage;
        case (state)
            IDLE: begin
                next_cnt   = '0;
                next_stage = '0;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (cnt == LAT_CNT) begin
                    next_cnt = '0;
                    if (stage == LAST_STAGE) begin
                        next_state = DONE;
                        next_stage = '0;
                    end else begin
                        next_stage = stage + 3'd1;
                    end
                end else begin
                    next_cnt = cnt + 4'd1;
                end
            end
            DONE: begin
                next_cnt   = '0;
                next_stage = '0;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
                next_stage = '0;
            end
        endcase
        // Abort wins over every other transition, but only once a frame is in flight.
        if (abort && state != IDLE) begin
            next_state = IDLE;
            next_cnt   = '0;
            next_stage = '0;
        end
    end

    always_comb begin
        in_ready   = (state == IDLE);
        buf_load   = in_valid & (state == IDLE);
        busy       = (state == RUN) || (state == DONE);
        out_valid  = (state == DONE);
        bf_start_d = (next_state == RUN) && (next_cnt == 4'd0);
        buf_we_d   = (next_state == RUN) && (next_cnt == LAT_CNT);
        tw_idx_d   = (next_state == RUN) ? tw_next : '0;
        state_dbg  = state;
    end

`ifdef FFT_CTRL_INVERSE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tw_conj <= 1'b0;
        end else if (next_state == IDLE) begin
            tw_conj <= 1'b0;
        end else if (buf_load) begin
            tw_conj <= inv_req;
        end
    end
`endif

endmodule
